// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet stage sequencer: FSM state type and default budgets.
package lenet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_HOLD,
    S_ERR
  } state_t;

  // Cycle count of the convolution stage at the reference image size.
  localparam int unsigned CONV_STAGE_CYCLES = 75070;

endpackage

// File: rtl/lenet_stage_timer.sv
// Per-stage cycle counter with clear/enable, saturation and terminal-count compare
// against the current stage budget (a budget of 0 behaves as 1).
module lenet_stage_timer #(
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] budget,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] eff_budget;

  assign eff_budget = (budget == '0) ? CNT_WIDTH'(1) : budget;
  assign tc         = (count == (eff_budget - CNT_WIDTH'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/lenet_stage_sequencer.sv
// Releases downstream stage resets in order, advancing on a cycle budget (TIMED)
// or a done pulse with timeout (HANDSHAKE); provides start/abort and status flags.
module lenet_stage_sequencer
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_WIDTH  = 20,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_STAGES-1:0]           stage_mode,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0] stage_cycles,
  input  logic [NUM_STAGES-1:0]           stage_done,
  output logic [NUM_STAGES-1:0]           stage_rst,
  output logic [IDX_WIDTH-1:0]            cur_stage,
  output logic                            busy,
  output logic                            seq_done,
  output logic                            seq_error
);

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_STAGES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] budget;
  logic                 mode_k;
  logic                 done_k;
  logic                 tc;
  logic                 run;
  logic                 advance;
  logic                 timeout;
  logic                 timer_clr;

  // Select budget, mode and done of the running stage; other stages' done bits are ignored.
  always_comb begin
    budget = '0;
    mode_k = 1'b0;
    done_k = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (cur_stage == IDX_WIDTH'(k)) begin
        budget = stage_cycles[k*CNT_WIDTH +: CNT_WIDTH];
        mode_k = stage_mode[k];
        done_k = stage_done[k];
      end
    end
  end

  assign run       = (state == S_RUN);
  assign advance   = run && (mode_k ? done_k : tc);
  assign timeout   = run && mode_k && !done_k && tc;
  assign timer_clr = !run || advance || timeout || abort;

  function automatic logic [NUM_STAGES-1:0] thermo(input logic [IDX_WIDTH-1:0] idx);
    logic [NUM_STAGES-1:0] t;
    t = '0;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      t[j] = (IDX_WIDTH'(j) > idx);
    end
    return t;
  endfunction

  lenet_stage_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (run),
    .budget (budget),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      stage_rst <= '1;
      cur_stage <= '0;
      busy      <= 1'b0;
      seq_done  <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        stage_rst <= '1;
        cur_stage <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_HOLD, S_ERR: begin
            if (start) begin
              state     <= S_FLUSH;
              seq_error <= 1'b0;
              busy      <= 1'b1;
              stage_rst <= '1;
              cur_stage <= '0;
            end
          end
          S_FLUSH: begin
            state     <= S_RUN;
            stage_rst <= thermo('0);
          end
          S_RUN: begin
            if (advance) begin
              if (cur_stage == LAST) begin
                state     <= S_HOLD;
                seq_done  <= 1'b1;
                busy      <= 1'b0;
                stage_rst <= '0;
              end else begin
                cur_stage <= cur_stage + 1'b1;
                stage_rst <= thermo(cur_stage + 1'b1);
              end
            end else if (timeout) begin
              state     <= S_ERR;
              seq_error <= 1'b1;
              busy      <= 1'b0;
              stage_rst <= '1;
            end
          end
          default: begin
            state     <= S_IDLE;
            stage_rst <= '1;
            cur_stage <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lenet_stage_sequencer.sv
// Scoreboard bench: each output change is popped against a queue of expected
// {cycle, stage_rst, cur_stage, busy, seq_done, seq_error} snapshots.
module tb_lenet_stage_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned CW = 20;
  localparam int unsigned IW = 2;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [NS-1:0]    stage_mode   = '0;
  logic [NS*CW-1:0] stage_cycles = '0;
  logic [NS-1:0]    stage_done   = '0;
  logic [NS-1:0]    stage_rst;
  logic [IW-1:0]    cur_stage;
  logic             busy;
  logic             seq_done;
  logic             seq_error;

  int unsigned cyc      = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned t        = 0;

  typedef struct {
    string       name;
    int unsigned cyc;
    bit          chk_cyc;
    logic [7:0]  snap;
  } exp_t;

  exp_t exp_q[$];

  lenet_stage_sequencer #(
    .NUM_STAGES (NS),
    .CNT_WIDTH  (CW),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .stage_mode   (stage_mode),
    .stage_cycles (stage_cycles),
    .stage_done   (stage_done),
    .stage_rst    (stage_rst),
    .cur_stage    (cur_stage),
    .busy         (busy),
    .seq_done     (seq_done),
    .seq_error    (seq_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output snapshot must match the next expected entry.
  logic [7:0] prev;
  bit         first = 1'b1;
  always @(negedge clk) begin
    logic [7:0] snap;
    exp_t       e;
    snap = {stage_rst, cur_stage, busy, seq_done, seq_error};
    if (first || snap != prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, snap);
      end else begin
        e = exp_q.pop_front();
        if (snap !== e.snap || (e.chk_cyc && cyc != e.cyc)) begin
          failures++;
          $display("FAIL %s got=%b@%0d required=%b@%0d", e.name, snap, cyc, e.snap, e.cyc);
        end
      end
    end
    first = 1'b0;
    prev  = snap;
  end

  task automatic push(input string name, input int unsigned c, input logic [2:0] r,
                      input logic [1:0] s, input logic b, input logic d, input logic er);
    exp_t e;
    e.name    = name;
    e.cyc     = c;
    e.chk_cyc = 1'b1;
    e.snap    = {r, s, b, d, er};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned n);
    for (int unsigned i = 0; i < n && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    e.name = "reset"; e.cyc = 0; e.chk_cyc = 1'b0; e.snap = 8'b111_00_000;
    exp_q.push_back(e);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // TIMED, budgets s0=5 s1=3 s2=4; a start while busy must not restart
    stage_mode   = 3'b000;
    stage_cycles = {20'd4, 20'd3, 20'd5};
    t = cyc;
    push("t1_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t1_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t1_s1",    t+7,  3'b100, 2'd1, 1, 0, 0);
    push("t1_s2",    t+10, 3'b000, 2'd2, 1, 0, 0);
    push("t1_done",  t+14, 3'b000, 2'd2, 0, 1, 0);
    push("t1_hold",  t+15, 3'b000, 2'd2, 0, 0, 0);
    pulse_start();
    goto(t+5);
    pulse_start();
    wait_drain("t1", 40);

    // HANDSHAKE stage 1, re-run from HOLD through FLUSH; done in stage 0 ignored
    stage_mode   = 3'b010;
    stage_cycles = {20'd4, 20'd10, 20'd2};
    t = cyc;
    push("t2_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t2_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t2_s1",    t+4,  3'b100, 2'd1, 1, 0, 0);
    push("t2_s2",    t+8,  3'b000, 2'd2, 1, 0, 0);
    push("t2_done",  t+12, 3'b000, 2'd2, 0, 1, 0);
    push("t2_hold",  t+13, 3'b000, 2'd2, 0, 0, 0);
    pulse_start();
    goto(t+2);
    stage_done = 3'b010;
    tick();
    stage_done = 3'b000;
    goto(t+7);
    stage_done = 3'b010;
    tick();
    stage_done = 3'b000;
    wait_drain("t2", 40);

    // HANDSHAKE timeout after 10 cycles in stage 1
    t = cyc;
    push("t3_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t3_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t3_s1",    t+4,  3'b100, 2'd1, 1, 0, 0);
    push("t3_err",   t+14, 3'b111, 2'd1, 0, 0, 1);
    pulse_start();
    wait_drain("t3", 40);

    // start from ERR clears seq_error; abort+start in stage 1 returns to IDLE
    t = cyc;
    push("t4_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t4_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t4_s1",    t+4,  3'b100, 2'd1, 1, 0, 0);
    push("t4_abort", t+7,  3'b111, 2'd0, 0, 0, 0);
    pulse_start();
    goto(t+6);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    wait_drain("t4", 40);

    // done and timeout coincide in stage 1 (budget 3, done at counter 2): advance wins
    stage_cycles = {20'd4, 20'd3, 20'd2};
    t = cyc;
    push("t5_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t5_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t5_s1",    t+4,  3'b100, 2'd1, 1, 0, 0);
    push("t5_s2",    t+7,  3'b000, 2'd2, 1, 0, 0);
    push("t5_done",  t+11, 3'b000, 2'd2, 0, 1, 0);
    push("t5_hold",  t+12, 3'b000, 2'd2, 0, 0, 0);
    pulse_start();
    goto(t+6);
    stage_done = 3'b010;
    tick();
    stage_done = 3'b000;
    wait_drain("t5", 40);

    // asynchronous reset in stage 2: immediate reset values, no seq_done afterwards
    stage_mode   = 3'b000;
    stage_cycles = {20'd4, 20'd3, 20'd5};
    t = cyc;
    push("t6_flush", t+1,  3'b111, 2'd0, 1, 0, 0);
    push("t6_s0",    t+2,  3'b110, 2'd0, 1, 0, 0);
    push("t6_s1",    t+7,  3'b100, 2'd1, 1, 0, 0);
    push("t6_s2",    t+10, 3'b000, 2'd2, 1, 0, 0);
    push("t6_reset", t+12, 3'b111, 2'd0, 0, 0, 0);
    pulse_start();
    goto(t+12);
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_drain("t6", 40);
    repeat (10) tick();

    // budget 0 on stage 0 lasts one cycle; budget 75070 on stage 1 counts without wrap
    stage_cycles = {20'd1, 20'd75070, 20'd0};
    t = cyc;
    push("t7_flush", t+1,     3'b111, 2'd0, 1, 0, 0);
    push("t7_s0",    t+2,     3'b110, 2'd0, 1, 0, 0);
    push("t7_s1",    t+3,     3'b100, 2'd1, 1, 0, 0);
    push("t7_s2",    t+75073, 3'b000, 2'd2, 1, 0, 0);
    push("t7_done",  t+75074, 3'b000, 2'd2, 0, 1, 0);
    push("t7_hold",  t+75075, 3'b000, 2'd2, 0, 0, 0);
    pulse_start();
    wait_drain("t7", 75200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
